// File: rtl/lb_pkg.sv
// Shared definitions for the line window buffer: default pixel width, output
// reset value, marker bundle and the tap slice helper.
package lb_pkg;

    localparam int   DATA_W_DEFAULT = 8;
    localparam logic OUT_RST        = 1'b0;

    typedef struct packed {
        logic eol;
        logic sof;
        logic ready;
    } lb_marks_t;

    // LSB index of tap k inside a packed column of w-bit taps.
    function automatic int tapLsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/lb_line_ram.sv
// Single-port LINE_W x DATA_W line store with write enable and no reset.
// The read port is combinational, so a write cycle returns the pre-write word.
module lb_line_ram #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 514,
    parameter int ADDR_W = $clog2(LINE_W)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [LINE_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Vertical NUM_LINES-tap column generator over NUM_LINES-1 cascaded line RAMs.
// Define LB_BORDER_REPLICATE_EN to replicate the topmost valid row into masked taps.
module line_window_buffer
    import lb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int LINE_W    = 514,
    parameter int NUM_LINES = 3,
    parameter int COL_W     = $clog2(LINE_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic                        sof,
    input  logic [DATA_W-1:0]           PixelData,
    output logic                        out_valid,
    output logic [NUM_LINES*DATA_W-1:0] taps_out,
    output logic [COL_W-1:0]            col_out,
    output logic                        eol_out,
    output logic                        sof_out,
    output logic                        lines_ready
);

    localparam int               NUM_RAMS = NUM_LINES - 1;
    localparam int               FILL_W   = $clog2(NUM_LINES);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(LINE_W - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(NUM_LINES - 1);

    logic [COL_W-1:0]            colPtr_q, colPtr_d;
    logic [FILL_W-1:0]           fill_q, fill_d;
    logic [NUM_LINES*DATA_W-1:0] taps_q, taps_d;
    logic [COL_W-1:0]            colOut_q;
    logic                        outValid_q;
    lb_marks_t                   marks_q, marks_d;

    logic [COL_W-1:0]  curCol;
    logic [FILL_W-1:0] curFill;
    logic [DATA_W-1:0] colVals [NUM_LINES];
    logic [DATA_W-1:0] maskVal;

    // A frame start restarts the column and discards any partial fill.
    assign curCol     = sof ? '0 : colPtr_q;
    assign curFill    = sof ? '0 : fill_q;
    assign colVals[0] = PixelData;

    for (genvar k = 1; k <= NUM_RAMS; k++) begin : gen_line
        lb_line_ram #(
            .DATA_W (DATA_W),
            .LINE_W (LINE_W),
            .ADDR_W (COL_W)
        ) u_ram (
            .clk     (clk),
            .we_i    (in_valid),
            .addr_i  (curCol),
            .wdata_i (colVals[k-1]),
            .rdata_o (colVals[k])
        );
    end

`ifdef LB_BORDER_REPLICATE_EN
    assign maskVal = colVals[curFill];
`else
    assign maskVal = '0;
`endif

    // Taps above the rows filled so far are masked so stale RAM data never escapes.
    always_comb begin
        taps_d = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            taps_d[tapLsb(k, DATA_W) +: DATA_W] = (k > int'(curFill)) ? maskVal : colVals[k];
        end
        colPtr_d      = (curCol == LAST_COL) ? '0 : curCol + COL_W'(1);
        fill_d        = ((curCol == LAST_COL) && (curFill != FULL)) ? curFill + FILL_W'(1) : curFill;
        marks_d.eol   = (curCol == LAST_COL);
        marks_d.sof   = sof;
        marks_d.ready = (curFill == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colPtr_q   <= '0;
            fill_q     <= '0;
            taps_q     <= {(NUM_LINES*DATA_W){OUT_RST}};
            colOut_q   <= {COL_W{OUT_RST}};
            marks_q    <= '{eol: OUT_RST, sof: OUT_RST, ready: OUT_RST};
            outValid_q <= OUT_RST;
        end else begin
            outValid_q <= in_valid;
            if (in_valid) begin
                colPtr_q <= colPtr_d;
                fill_q   <= fill_d;
                taps_q   <= taps_d;
                colOut_q <= curCol;
                marks_q  <= marks_d;
            end
        end
    end

    assign out_valid   = outValid_q;
    assign taps_out    = taps_q;
    assign col_out     = colOut_q;
    assign eol_out     = marks_q.eol;
    assign sof_out     = marks_q.sof;
    assign lines_ready = marks_q.ready;

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer with LINE_W=4, NUM_LINES=3.
// Define LB_BORDER_REPLICATE_EN for both bench and RTL to check the replicate build.
module tb_line_window_buffer;

   localparam int DW = 8;
   localparam int LW = 4;
   localparam int NL = 3;
   localparam int CW = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 sof;
   logic [DW-1:0]        PixelData;
   logic                 out_valid;
   logic [NL*DW-1:0]     taps_out;
   logic [CW-1:0]        col_out;
   logic                 eol_out;
   logic                 sof_out;
   logic                 lines_ready;

   typedef struct packed {
      logic [NL*DW-1:0] taps;
      logic [CW-1:0]    col;
      logic             eol;
      logic             sofo;
      logic             ready;
   } exp_t;

   exp_t          expQ[$];
   int            errors = 0;
   int            checks = 0;
   int            mRow;
   int            mCol;
   logic [DW-1:0] img [3][LW];
   logic [23:0]   tab [12];
   logic          expNow = 1'b0;

   line_window_buffer #(
      .DATA_W    (DW),
      .LINE_W    (LW),
      .NUM_LINES (NL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .sof         (sof),
      .PixelData   (PixelData),
      .out_valid   (out_valid),
      .taps_out    (taps_out),
      .col_out     (col_out),
      .eol_out     (eol_out),
      .sof_out     (sof_out),
      .lines_ready (lines_ready)
   );

   always #5 clk = ~clk;

   // Frame-level reference: a pixel's column holds the same column of earlier rows
   // of the current frame; rows that do not exist yet are masked or replicated.
   task automatic applyStimulus(input logic [DW-1:0] pix, input logic sofIn,
                                input bit useTab, input logic [23:0] tabVal, input int gap);
      exp_t e;
      int   f;
      if (sofIn) begin
         mRow = 0;
         mCol = 0;
      end
      img[mRow % 3][mCol] = pix;
      f = (mRow < 2) ? mRow : 2;
      for (int k = 0; k < NL; k++) begin
         if (k <= f) e.taps[k*DW +: DW] = img[(mRow - k) % 3][mCol];
`ifdef LB_BORDER_REPLICATE_EN
         else e.taps[k*DW +: DW] = img[(mRow - f) % 3][mCol];
`else
         else e.taps[k*DW +: DW] = '0;
`endif
      end
      if (useTab) e.taps = tabVal;
      e.col   = CW'(mCol);
      e.eol   = (mCol == LW - 1);
      e.sofo  = sofIn;
      e.ready = (mRow >= 2);
      expQ.push_back(e);
      mCol = mCol + 1;
      if (mCol == LW) begin
         mCol = 0;
         mRow = mRow + 1;
      end
      in_valid  = 1'b1;
      sof       = sofIn;
      PixelData = pix;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      sof      = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t got;
      got = '{taps: taps_out, col: col_out, eol: eol_out, sofo: sof_out, ready: lines_ready};
      checks++;
      if (got !== e) begin
         errors++;
         $display("[TB] FAIL column: got taps=%h col=%0d eol=%b sof=%b ready=%b, required taps=%h col=%0d eol=%b sof=%b ready=%b",
                  got.taps, got.col, got.eol, got.sofo, got.ready,
                  e.taps, e.col, e.eol, e.sofo, e.ready);
      end
   endtask

   task automatic checkZero(input string name);
      checks++;
      if ({out_valid, taps_out, col_out, eol_out, sof_out, lines_ready} !== '0) begin
         errors++;
         $display("[TB] FAIL %s: got valid=%b taps=%h col=%0d eol=%b sof=%b ready=%b, required all zero",
                  name, out_valid, taps_out, col_out, eol_out, sof_out, lines_ready);
      end
   endtask

   // Output is owed exactly one cycle after every cycle the bench drove in_valid.
   always @(posedge clk) expNow <= in_valid && !rst;

   // Monitor pops one expectation per presented column.
   always @(negedge clk) begin
      if (out_valid || expNow) begin
         checks++;
         if (out_valid !== expNow) begin
            errors++;
            $display("[TB] FAIL out_valid: got %b, required %b", out_valid, expNow);
         end
      end
      if (out_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got a column, required none");
         end else begin
            checkOutput(expQ.pop_front());
         end
      end
   end

   initial begin
`ifdef LB_BORDER_REPLICATE_EN
      tab = '{24'h010101, 24'h020202, 24'h030303, 24'h040404,
              24'h010105, 24'h020206, 24'h030307, 24'h040408,
              24'h010509, 24'h02060A, 24'h03070B, 24'h04080C};
`else
      tab = '{24'h000001, 24'h000002, 24'h000003, 24'h000004,
              24'h000105, 24'h000206, 24'h000307, 24'h000408,
              24'h010509, 24'h02060A, 24'h03070B, 24'h04080C};
`endif
      rst       = 1'b1;
      in_valid  = 1'b0;
      sof       = 1'b0;
      PixelData = '0;
      mRow      = 0;
      mCol      = 0;
      #12;
      checkZero("reset_initial");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkZero("idle_after_reset");

      $display("[TB] pixels before first sof");
      applyStimulus(8'h33, 1'b0, 1'b0, '0, 0);
      applyStimulus(8'h34, 1'b0, 1'b0, '0, 0);

      $display("[TB] fill sequence");
      for (int i = 0; i < 12; i++) applyStimulus(DW'(i + 1), i == 0, 1'b1, tab[i], 0);

      $display("[TB] stalled fill sequence");
      for (int i = 0; i < 12; i++)
         applyStimulus(DW'(i + 1), i == 0, 1'b1, tab[i], int'($urandom_range(1, 3)));

      $display("[TB] second frame over stale data");
      for (int i = 0; i < 12; i++) applyStimulus(DW'(8'h80 + i), i == 0, 1'b0, '0, 0);

      $display("[TB] mid-line sof");
      for (int i = 0; i < 10; i++) applyStimulus(DW'(8'h40 + i), i == 0, 1'b0, '0, 0);
      for (int i = 0; i < 12; i++) applyStimulus(DW'(8'hC0 + i), i == 0, 1'b0, '0, 0);

      $display("[TB] asynchronous reset mid-stream");
      for (int i = 0; i < 3; i++) applyStimulus(DW'(8'h55 + i), 1'b0, 1'b0, '0, 0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkZero("async_reset");
      @(posedge clk);
      #1;
      checkZero("reset_held");
      rst  = 1'b0;
      mRow = 0;
      mCol = 0;
      @(posedge clk);
      #1;
      checkZero("after_release");
      for (int i = 0; i < 6; i++) applyStimulus(DW'(8'hE0 + i), 1'b0, 1'b0, '0, 0);

      repeat (3) @(posedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d columns still owed, required 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
